// File: rtl/cmd_sequencer_if.sv
// Command/response link between the sequencer and RemoteComm.
interface cmd_sequencer_if;
  logic        send_cmd;
  logic [15:0] cmd;
  logic        resp_rdy;
  logic [7:0]  resp;

  modport master (output send_cmd, cmd, input resp_rdy, resp);
  modport slave  (input send_cmd, cmd, output resp_rdy, resp);
endinterface

// File: rtl/cmd_sequencer.sv
// Buffers up to DEPTH 16-bit commands and issues them one at a time to RemoteComm,
// waiting for an 0xA5 acknowledge (and for SOLVE commands, the hall sensor).
module cmd_sequencer #(
  parameter int DEPTH   = 16,
  parameter int TMO_CYC = 2**20
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wr_en,
  input  logic [15:0]             wr_data,
  input  logic                    clr,
  input  logic                    start,
  input  logic                    abort,
  cmd_sequencer_if.master         link,
  input  logic                    hall_n,
  output logic                    busy,
  output logic                    done,
  output logic                    err,
  output logic [1:0]              err_code,
  output logic [$clog2(DEPTH):0]  count,
  output logic [$clog2(DEPTH)-1:0] idx
);
  localparam int AW = $clog2(DEPTH);
  localparam int TW = $clog2(TMO_CYC) + 1;
  localparam logic [AW:0]   FULL     = (AW+1)'(DEPTH);
  // WAIT starts the cycle after send_cmd, so this gives exactly TMO_CYC cycles
  // from the strobe to the last cycle in which a response is still accepted.
  localparam logic [TW-1:0] TMO_LAST = TW'(TMO_CYC - 2);

  typedef enum logic [2:0] {IDLE, SEND, WAIT, NEXT, SOLVE, ERR} state_t;

  state_t        state, state_d;
  logic [15:0]   mem [DEPTH];
  logic [TW-1:0] tmo;
  logic [15:0]   cur;
  logic          ctl, last, done_d, err_set;
  logic [1:0]    code_d;

  assign ctl  = (state == IDLE) || (state == ERR);
  assign busy = state inside {SEND, WAIT, SOLVE, NEXT};
  assign cur  = mem[idx];
  assign last = ({1'b0, idx} == count - (AW+1)'(1));

  assign link.send_cmd = (state == SEND) && !abort;
  assign link.cmd      = (state inside {SEND, WAIT, SOLVE}) ? cur : '0;

  always_comb begin
    state_d = state;
    done_d  = 1'b0;
    err_set = 1'b0;
    code_d  = 2'b00;
    case (state)
      IDLE, ERR: begin
        if (clr) state_d = IDLE;
        else if (start) begin
          if (count != '0) state_d = SEND;
          else begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end
      SEND: state_d = WAIT;
      WAIT: begin
        if (link.resp_rdy) begin
          if (link.resp == 8'hA5) state_d = (cur[15:13] == 3'b011) ? SOLVE : NEXT;
          else begin
            state_d = ERR;
            err_set = 1'b1;
            code_d  = 2'b01;
          end
        end else if (tmo == TMO_LAST) begin
          state_d = ERR;
          err_set = 1'b1;
          code_d  = 2'b10;
        end
      end
      SOLVE: if (!hall_n) state_d = NEXT;
      NEXT: begin
        if (last) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else state_d = SEND;
      end
      default: state_d = IDLE;
    endcase
    if (busy && abort) begin
      state_d = ERR;
      err_set = 1'b1;
      code_d  = 2'b11;
      done_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (ctl && !clr && wr_en && count != FULL) mem[count[AW-1:0]] <= wr_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      count    <= '0;
      idx      <= '0;
      tmo      <= '0;
      done     <= 1'b0;
      err      <= 1'b0;
      err_code <= '0;
    end else begin
      state <= state_d;
      done  <= done_d;
      tmo   <= (state == WAIT) ? tmo + TW'(1) : '0;
      if (err_set) begin
        err      <= 1'b1;
        err_code <= code_d;
      end else if (ctl && (clr || start)) begin
        err      <= 1'b0;
        err_code <= '0;
      end
      if (ctl) begin
        if (clr) count <= '0;
        else if (wr_en && count != FULL) count <= count + (AW+1)'(1);
      end
      if (ctl && (clr || start)) idx <= '0;
      else if (state == NEXT && !abort) idx <= last ? '0 : idx + AW'(1);
    end
  end
endmodule

// File: tb/tb_cmd_sequencer.sv
// Directed and randomized checks of cmd_sequencer against a queue-based model of the
// command buffer; a second instance with a short timeout covers the timeout path.
module tb_cmd_sequencer;
  localparam int DEPTH = 4;

  logic        clk = 1'b0, rst = 1'b0;
  logic        wr_en = 1'b0, clr = 1'b0, start = 1'b0, abort = 1'b0, hall_n = 1'b1;
  logic        resp_rdy = 1'b0;
  logic [15:0] wr_data = '0;
  logic [7:0]  resp = '0, bad = 8'h5A;

  logic busy_a, done_a, err_a, busy_b, done_b, err_b;
  logic [1:0] code_a, code_b, idx_a, idx_b;
  logic [2:0] count_a, count_b;

  cmd_sequencer_if link_a();
  cmd_sequencer_if link_b();
  assign link_a.resp_rdy = resp_rdy;
  assign link_a.resp     = resp;
  assign link_b.resp_rdy = resp_rdy;
  assign link_b.resp     = resp;

  cmd_sequencer #(.DEPTH(DEPTH), .TMO_CYC(1024)) u_main (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .clr(clr), .start(start),
    .abort(abort), .link(link_a.master), .hall_n(hall_n), .busy(busy_a), .done(done_a),
    .err(err_a), .err_code(code_a), .count(count_a), .idx(idx_a));

  cmd_sequencer #(.DEPTH(DEPTH), .TMO_CYC(64)) u_tmo (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .clr(clr), .start(start),
    .abort(abort), .link(link_b.master), .hall_n(hall_n), .busy(busy_b), .done(done_b),
    .err(err_b), .err_code(code_b), .count(count_b), .idx(idx_b));

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;
  logic [15:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_send"}, link_a.send_cmd, 0);
    chk({tag, "_cmd"}, link_a.cmd, 0);
    chk({tag, "_busy"}, busy_a, 0);
    chk({tag, "_done"}, done_a, 0);
    chk({tag, "_err"}, err_a, 0);
    chk({tag, "_code"}, code_a, 0);
    chk({tag, "_count"}, count_a, 0);
    chk({tag, "_idx"}, idx_a, 0);
  endtask

  task automatic do_clr();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    exp_q.delete();
  endtask

  task automatic load(input logic [15:0] v);
    wr_en = 1'b1;
    wr_data = v;
    tick();
    wr_en = 1'b0;
    if (exp_q.size() < DEPTH) exp_q.push_back(v);
  endtask

  task automatic wait_send(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (link_a.send_cmd === 1'b1) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  // Runs the loaded queue once; fixed_d<0 means random response latency,
  // bad_at is the index answered with a non-0xA5 byte (-1 for none).
  task automatic run_cmds(input int fixed_d, input int bad_at);
    bit ok;
    int d;
    logic [15:0] c;
    start = 1'b1;
    tick();
    start = 1'b0;
    foreach (exp_q[i]) begin
      wait_send(ok);
      chk("send_seen", ok, 1);
      if (!ok) return;
      c = exp_q[i];
      chk("send_cmd", link_a.cmd, c);
      chk("send_idx", idx_a, i);
      tick();
      chk("no_back2back", link_a.send_cmd, 0);
      chk("cmd_in_wait", link_a.cmd, c);
      d = (fixed_d >= 0) ? fixed_d : int'($urandom_range(0, 20));
      repeat (d) tick();
      resp_rdy = 1'b1;
      resp = (i == bad_at) ? bad : 8'hA5;
      tick();
      resp_rdy = 1'b0;
      if (i == bad_at) begin
        chk("bad_err", err_a, 1);
        chk("bad_code", code_a, 2'b01);
        chk("bad_busy", busy_a, 0);
        chk("bad_idx", idx_a, i);
        return;
      end
      if (c[15:13] == 3'b011) begin
        chk("solve_busy", busy_a, 1);
        chk("solve_cmd", link_a.cmd, c);
        repeat ($urandom_range(0, 10)) tick();
        hall_n = 1'b0;
        tick();
        hall_n = 1'b1;
      end
      chk("next_busy", busy_a, 1);
      chk("next_cmd", link_a.cmd, 0);
      tick();
    end
    chk("end_done", done_a, 1);
    chk("end_busy", busy_a, 0);
    chk("end_err", err_a, 0);
    chk("end_idx", idx_a, 0);
    tick();
    chk("done_pulse", done_a, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int s, low;
    #1 rst = 1'b1;
    #1 chk_zero("reset");
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    tick();

    // empty buffer: start just pulses done
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("empty_done", done_a, 1);
    chk("empty_busy", busy_a, 0);
    tick();
    chk("empty_done_pulse", done_a, 0);

    // three commands, responses 100 cycles after each strobe
    do_clr();
    load(16'h0000);
    load(16'h4000);
    load(16'h23FF);
    chk("count3", count_a, 3);
    run_cmds(99, -1);

    // bad response on first command
    do_clr();
    load(16'h4000);
    load(16'h2000);
    bad = 8'h5A;
    run_cmds(-1, 0);
    s = 0;
    repeat (150) begin
      tick();
      if (link_a.send_cmd === 1'b1) s++;
    end
    chk("no_resend_after_err", s, 0);

    // timeout on the TMO_CYC=64 instance
    do_clr();
    load(16'h4000);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("tmo_send", link_b.send_cmd, 1);
    repeat (63) tick();
    chk("tmo_code_63", code_b, 2'b00);
    chk("tmo_busy_63", busy_b, 1);
    tick();
    chk("tmo_code_64", code_b, 2'b10);
    chk("tmo_err_64", err_b, 1);
    chk("tmo_busy_64", busy_b, 0);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_wait_code", code_a, 2'b11);

    // response on the final allowed cycle beats the timeout
    do_clr();
    load(16'h4000);
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (63) tick();
    resp_rdy = 1'b1;
    resp = 8'hA5;
    tick();
    resp_rdy = 1'b0;
    chk("tmo_race_err", err_b, 0);
    chk("tmo_race_busy", busy_b, 1);
    tick();
    chk("tmo_race_done", done_b, 1);

    // SOLVE waits for the hall sensor; inputs while busy are ignored
    do_clr();
    load(16'h6000);
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    resp_rdy = 1'b1;
    resp = 8'hA5;
    tick();
    resp_rdy = 1'b0;
    low = 0;
    for (int j = 0; j < 500; j++) begin
      if (j == 100) start = 1'b1;
      if (j == 200) clr = 1'b1;
      if (j == 300) begin
        wr_en = 1'b1;
        wr_data = 16'hBEEF;
      end
      tick();
      start = 1'b0;
      clr = 1'b0;
      wr_en = 1'b0;
      if (busy_a !== 1'b1 || link_a.send_cmd !== 1'b0) low++;
    end
    chk("solve_hold", low, 0);
    chk("solve_count", count_a, 1);
    hall_n = 1'b0;
    tick();
    hall_n = 1'b1;
    chk("hall_next_busy", busy_a, 1);
    chk("hall_next_done", done_a, 0);
    tick();
    chk("hall_done", done_a, 1);
    chk("hall_busy", busy_a, 0);

    // overfill, abort in SEND, re-run from ERR, reset mid-WAIT
    do_clr();
    for (int k = 0; k < DEPTH + 2; k++) load(16'h1000 + 16'(k));
    chk("count_sat", count_a, DEPTH);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("sat_send", link_a.send_cmd, 1);
    abort = 1'b1;
    #1 chk("abort_suppress", link_a.send_cmd, 0);
    tick();
    abort = 1'b0;
    chk("abort_send_code", code_a, 2'b11);
    chk("abort_send_busy", busy_a, 0);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("rerun_cmd", link_a.cmd, 16'h1000);
    chk("rerun_err", err_a, 0);
    tick();
    chk("rerun_wait_busy", busy_a, 1);
    #2 rst = 1'b1;
    #1 chk_zero("async_rst");
    @(posedge clk);
    #1 rst = 1'b0;
    exp_q.delete();
    chk_zero("after_rst");
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("rst_start_done", done_a, 1);
    s = 0;
    repeat (20) begin
      tick();
      if (link_a.send_cmd === 1'b1) s++;
    end
    chk("rst_no_send", s, 0);

    // randomized sequences against the queue model
    for (int it = 0; it < 8; it++) begin
      int n, bad_at;
      logic [15:0] c;
      do_clr();
      n = $urandom_range(1, DEPTH + 2);
      for (int k = 0; k < n; k++) begin
        c = 16'($urandom);
        if ($urandom_range(0, 2) == 0) c[15:13] = 3'b011;
        load(c);
      end
      chk("rand_count", count_a, exp_q.size());
      bad_at = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, exp_q.size() - 1)) : -1;
      bad = 8'($urandom);
      if (bad == 8'hA5) bad = 8'h00;
      run_cmds(-1, bad_at);
      if (bad_at >= 0) run_cmds(-1, -1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
